cpu_bus_arbiter: RTL and testbench

- Sits directly downstream of the CPU core's instruction and data ports.
- Both ports use the sram-like request/response protocol: req held until addr_ok, then an in-order data_ok response.
- The block merges the two ports onto one shared sram-like bus towards memory/bridge logic.
- Data port has fixed priority. A tag FIFO records which port owns each outstanding transaction, so responses are routed back in order.

---
 rtl/cpu_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter.sv
// Merges the CPU instruction and data sram-like ports onto one shared bus; data has fixed priority.
// Latency: zero added cycles on both the request path and the response path (all muxing is combinational).
// Backpressure: bus_addr_ok stalls the granted source; bus_req drops while DEPTH transactions are outstanding.
module cpu_bus_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_addr_ok,
    input  logic [31:0] bus_rdata,
    input  logic        bus_data_ok
);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_INST = 2'd1,
        SRC_DATA = 2'd2
    } src_t;

    src_t             lock_q;
    src_t             lock_d;
    src_t             grant;
    logic             granted_req;
    logic             full;
    logic             push;
    logic             pop;
    logic             head_data;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [DEPTH-1:0] tag_mem;
    logic [3:0]       data_strb;

    // A held lock pins the grant so a presented request cannot be swapped out before acceptance.
    always_comb begin
        grant = SRC_NONE;
        if (lock_q != SRC_NONE) begin
            grant = lock_q;
        end else if (data_req) begin
            grant = SRC_DATA;
        end else if (inst_req) begin
            grant = SRC_INST;
        end
    end

    always_comb begin
        granted_req = 1'b0;
        case (grant)
            SRC_INST: granted_req = inst_req;
            SRC_DATA: granted_req = data_req;
            default:  granted_req = 1'b0;
        endcase
    end

    assign full      = (count == (PTR_W + 1)'(DEPTH));
    assign bus_req   = resetn & granted_req & ~full;
    assign push      = bus_req & bus_addr_ok;
    assign pop       = resetn & bus_data_ok & (count != '0);
    assign head_data = tag_mem[rptr];

    assign inst_addr_ok = push & (grant == SRC_INST);
    assign data_addr_ok = push & (grant == SRC_DATA);
    assign inst_data_ok = pop & ~head_data;
    assign data_data_ok = pop & head_data;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    always_comb begin
        data_strb = 4'b0000;
        if (data_wr) begin
            case (data_size)
                2'd0:    data_strb = 4'b0001 << data_addr[1:0];
                2'd1:    data_strb = 4'b0011 << data_addr[1:0];
                default: data_strb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        bus_wr    = 1'b0;
        bus_size  = 2'd0;
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        bus_wstrb = 4'b0000;
        case (grant)
            SRC_INST: begin
                bus_size = 2'd2;
                bus_addr = inst_addr;
            end
            SRC_DATA: begin
                bus_wr    = data_wr;
                bus_size  = data_size;
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
                bus_wstrb = data_strb;
            end
            default: ;
        endcase
    end

    always_comb begin
        lock_d = lock_q;
        case (lock_q)
            SRC_NONE: if (bus_req && !bus_addr_ok) lock_d = grant;
            default:  if (push) lock_d = SRC_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q <= SRC_NONE;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Tag FIFO: one bit per outstanding transaction, 1 means the data port owns it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_mem <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tag_mem[wptr] <= (grant == SRC_DATA);
                wptr          <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Randomized and directed bench for cpu_bus_arbiter against a queue-based ownership model.
module tb_cpu_bus_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok;
    logic [31:0] bus_rdata;
    logic        bus_data_ok;

    int n_tests = 0;
    int n_fail  = 0;
    int mq[$];       // owners of outstanding transactions, oldest first: 0 inst, 1 data
    int held = 0;    // source pinned by an unaccepted request: 0 none, 1 inst, 2 data
    int last_hs = 0; // source accepted at the most recent edge

    cpu_bus_arbiter #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_addr_ok(bus_addr_ok),
        .bus_rdata(bus_rdata), .bus_data_ok(bus_data_ok)
    );

    always #5 clk = ~clk;

    function automatic int exp_grant();
        if (held != 0) return held;
        if (data_req) return 2;
        if (inst_req) return 1;
        return 0;
    endfunction

    function automatic logic exp_bus_req();
        int g = exp_grant();
        return resetn && ((g == 1 && inst_req) || (g == 2 && data_req)) && (mq.size() < DEPTH);
    endfunction

    function automatic logic [3:0] exp_strb();
        int sh = int'(data_addr[1:0]);
        if (!data_wr) return 4'h0;
        if (data_size == 2'd0) return 4'((1 << sh) & 15);
        if (data_size == 2'd1) return 4'((3 << sh) & 15);
        return 4'hF;
    endfunction

    task automatic tick();
        int   g;
        logic br;
        logic popf;
        @(posedge clk);
        if (!resetn) begin
            mq.delete();
            held    = 0;
            last_hs = 0;
        end else begin
            g       = exp_grant();
            br      = exp_bus_req();
            popf    = bus_data_ok && (mq.size() > 0);
            last_hs = (br && bus_addr_ok) ? g : 0;
            if (last_hs != 0) mq.push_back((g == 2) ? 1 : 0);
            if (popf) void'(mq.pop_front());
            if (held == 0 && br && !bus_addr_ok) held = g;
            else if (held != 0 && last_hs != 0) held = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        #2;
        n_tests++;
        if ({bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000", {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
        tick(); tick();
        n_tests++;
        if ({bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_held: got %b want 00000", {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
        inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; resetn = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus_req, inst_data_ok, data_data_ok} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want 000", {bus_req, inst_data_ok, data_data_ok});
        end
        tick();
    endtask

    task automatic test_single_fetch();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; bus_addr_ok = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus_req, inst_addr_ok, data_addr_ok} !== 3'b110) begin
            n_fail++;
            $display("FAIL fetch_addr_ok: got %b want 110", {bus_req, inst_addr_ok, data_addr_ok});
        end
        n_tests++;
        if ({bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !== {1'b0, 2'd2, 4'h0, 32'hBFC0_0000, 32'h0}) begin
            n_fail++;
            $display("FAIL fetch_fields: got wr=%b size=%0d strb=%h addr=%h want 0 2 0 bfc00000", bus_wr, bus_size, bus_wstrb, bus_addr);
        end
        tick();
        inst_req = 1'b0; bus_addr_ok = 1'b0;
        @(negedge clk);
        tick();
        bus_data_ok = 1'b1; bus_rdata = 32'h3C08_0001;
        @(negedge clk);
        n_tests++;
        if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h3C08_0001}) begin
            n_fail++;
            $display("FAIL fetch_resp: got ok=%b%b rdata=%h want 10 3c080001", inst_data_ok, data_data_ok, inst_rdata);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_count_zero: stray response got ok=%b%b want 00", inst_data_ok, data_data_ok);
        end
        tick();
        bus_data_ok = 1'b0;
    endtask

    task automatic test_conflict();
        inst_req = 1'b1; inst_addr = 32'h0000_0100;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h2000_0002; data_wdata = 32'h00AB_0000;
        bus_addr_ok = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({inst_addr_ok, data_addr_ok, bus_wr, bus_wstrb, bus_addr, bus_wdata} !== {3'b011, 4'b0100, 32'h2000_0002, 32'h00AB_0000}) begin
            n_fail++;
            $display("FAIL conflict_data_first: got iok=%b dok=%b wr=%b strb=%b addr=%h want 0 1 1 0100 20000002", inst_addr_ok, data_addr_ok, bus_wr, bus_wstrb, bus_addr);
        end
        tick();
        data_req = 1'b0; data_wr = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({inst_addr_ok, data_addr_ok, bus_addr} !== {2'b10, 32'h0000_0100}) begin
            n_fail++;
            $display("FAIL conflict_inst_second: got iok=%b dok=%b addr=%h want 1 0 00000100", inst_addr_ok, data_addr_ok, bus_addr);
        end
        tick();
        inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({inst_data_ok, data_data_ok} !== 2'b01) begin
            n_fail++;
            $display("FAIL conflict_resp0: got %b%b want 01", inst_data_ok, data_data_ok);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            n_fail++;
            $display("FAIL conflict_resp1: got %b%b want 10", inst_data_ok, data_data_ok);
        end
        tick();
        bus_data_ok = 1'b0;
    endtask

    task automatic test_lock_hold();
        inst_req = 1'b1; inst_addr = 32'h0000_0200; bus_addr_ok = 1'b0;
        data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_3000;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) data_req = 1'b1;
            if (c == 3) bus_addr_ok = 1'b1;
            @(negedge clk);
            n_tests++;
            if ({bus_req, inst_addr_ok, data_addr_ok, bus_addr} !== {1'b1, (c == 3), 1'b0, 32'h0000_0200}) begin
                n_fail++;
                $display("FAIL lock_hold_c%0d: got req=%b iok=%b dok=%b addr=%h want 1 %0d 0 00000200", c, bus_req, inst_addr_ok, data_addr_ok, bus_addr, (c == 3));
            end
            tick();
        end
        inst_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({data_addr_ok, bus_addr} !== {1'b1, 32'h0000_3000}) begin
            n_fail++;
            $display("FAIL lock_then_data: got dok=%b addr=%h want 1 00003000", data_addr_ok, bus_addr);
        end
        tick();
        data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            n_tests++;
            if ({inst_data_ok, data_data_ok} !== ((r == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL lock_resp%0d: got %b%b want %b", r, inst_data_ok, data_data_ok, (r == 0) ? 2'b10 : 2'b01);
            end
            tick();
        end
        bus_data_ok = 1'b0;
    endtask

    task automatic test_full();
        inst_req = 1'b1; bus_addr_ok = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            inst_addr = 32'h0000_1000 + 32'(4 * i);
            @(negedge clk);
            n_tests++;
            if (inst_addr_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL full_fill%0d: got iok=%b want 1", i, inst_addr_ok);
            end
            tick();
        end
        inst_addr = 32'h0000_1010;
        @(negedge clk);
        n_tests++;
        if ({bus_req, inst_addr_ok} !== 2'b00) begin
            n_fail++;
            $display("FAIL full_block: got req=%b iok=%b want 0 0", bus_req, inst_addr_ok);
        end
        tick();
        bus_data_ok = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus_req, inst_data_ok} !== 2'b01) begin
            n_fail++;
            $display("FAIL full_pop_same_cycle: got req=%b idok=%b want 0 1", bus_req, inst_data_ok);
        end
        tick();
        bus_data_ok = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus_req, inst_addr_ok, bus_addr} !== {2'b11, 32'h0000_1010}) begin
            n_fail++;
            $display("FAIL full_resume: got req=%b iok=%b addr=%h want 1 1 00001010", bus_req, inst_addr_ok, bus_addr);
        end
        tick();
        inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            n_tests++;
            if (inst_data_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL full_drain%0d: got idok=%b want 1", i, inst_data_ok);
            end
            tick();
        end
        bus_data_ok = 1'b0;
    endtask

    task automatic test_ordering();
        int pat[3] = '{0, 1, 0};
        data_wr = 1'b0; data_size = 2'd2;
        for (int rep = 0; rep < 3; rep++) begin
            bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
            for (int k = 0; k < 3; k++) begin
                inst_req = (pat[k] == 0); data_req = (pat[k] == 1);
                inst_addr = 32'(32'h400 + 16 * rep + 4 * k); data_addr = 32'(32'h800 + 16 * rep + 4 * k);
                @(negedge clk);
                n_tests++;
                if ({inst_addr_ok, data_addr_ok} !== ((pat[k] == 0) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL order_issue r%0d k%0d: got %b%b", rep, k, inst_addr_ok, data_addr_ok);
                end
                tick();
            end
            inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
            for (int k = 0; k < 3; k++) begin
                bus_rdata = $urandom;
                @(negedge clk);
                n_tests++;
                if ({inst_data_ok, data_data_ok, data_rdata} !== {((pat[k] == 0) ? 2'b10 : 2'b01), bus_rdata}) begin
                    n_fail++;
                    $display("FAIL order_resp r%0d k%0d: got %b%b rdata=%h want kind %0d rdata=%h", rep, k, inst_data_ok, data_data_ok, data_rdata, pat[k], bus_rdata);
                end
                tick();
            end
        end
        bus_data_ok = 1'b0;
    endtask

    task automatic test_random();
        logic ip = 1'b0;
        logic dp = 1'b0;
        int   g;
        logic br;
        logic popf;
        int   guard;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1'b1; inst_req = 1'b1; inst_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1'b1; data_req = 1'b1; data_wr = 1'($urandom_range(0, 1));
                data_size = 2'($urandom_range(0, 2)); data_addr = $urandom; data_wdata = $urandom;
                if (data_size == 2'd1) data_addr[0] = 1'b0;
                if (data_size == 2'd2) data_addr[1:0] = 2'b00;
            end
            bus_addr_ok = 1'($urandom_range(0, 1));
            bus_data_ok = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
            bus_rdata   = $urandom;
            @(negedge clk);
            g    = exp_grant();
            br   = exp_bus_req();
            popf = bus_data_ok && (mq.size() > 0);
            n_tests++;
            if ({bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !==
                {br, br && bus_addr_ok && g == 1, br && bus_addr_ok && g == 2,
                 popf && mq[0] == 0, popf && mq[0] == 1}) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc%0d: got %b want %b", cyc,
                    {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
                    {br, br && bus_addr_ok && g == 1, br && bus_addr_ok && g == 2, popf && mq[0] == 0, popf && mq[0] == 1});
            end
            if (g == 1) begin
                n_tests++;
                if ({bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !== {1'b0, 2'd2, 4'h0, inst_addr, 32'h0}) begin
                    n_fail++;
                    $display("FAIL rand_inst_fields cyc%0d: got addr=%h size=%0d strb=%h want %h 2 0", cyc, bus_addr, bus_size, bus_wstrb, inst_addr);
                end
            end
            if (g == 2) begin
                n_tests++;
                if ({bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !== {data_wr, data_size, exp_strb(), data_addr, data_wdata}) begin
                    n_fail++;
                    $display("FAIL rand_data_fields cyc%0d: got wr=%b size=%0d strb=%b addr=%h want %b %0d %b %h", cyc,
                        bus_wr, bus_size, bus_wstrb, bus_addr, data_wr, data_size, exp_strb(), data_addr);
                end
            end
            if (popf) begin
                n_tests++;
                if ({inst_rdata, data_rdata} !== {bus_rdata, bus_rdata}) begin
                    n_fail++;
                    $display("FAIL rand_rdata cyc%0d: got %h/%h want %h", cyc, inst_rdata, data_rdata, bus_rdata);
                end
            end
            tick();
            if (last_hs == 1) begin ip = 1'b0; inst_req = 1'b0; end
            if (last_hs == 2) begin dp = 1'b0; data_req = 1'b0; end
        end
        guard = 0;
        while ((ip || dp || mq.size() > 0) && guard < 200) begin
            bus_addr_ok = 1'b1;
            bus_data_ok = (mq.size() > 0);
            @(negedge clk);
            tick();
            if (last_hs == 1) begin ip = 1'b0; inst_req = 1'b0; end
            if (last_hs == 2) begin dp = 1'b0; data_req = 1'b0; end
            guard++;
        end
        n_tests++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL rand_drain: timed out with %0d outstanding", mq.size());
        end
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    endtask

    task automatic test_reset_mid();
        inst_req = 1'b1; bus_addr_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            inst_addr = 32'(32'h40 + 4 * i);
            @(negedge clk);
            tick();
        end
        inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80; bus_addr_ok = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus_req, data_addr_ok} !== 2'b10) begin
            n_fail++;
            $display("FAIL rmid_setup: got req=%b dok=%b want 1 0", bus_req, data_addr_ok);
        end
        tick();
        #2;
        resetn = 1'b0; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        #1;
        n_tests++;
        if ({bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
            n_fail++;
            $display("FAIL rmid_async: got %b want 00000", {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
        tick();
        resetn = 1'b1; data_req = 1'b0; bus_addr_ok = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            n_fail++;
            $display("FAIL rmid_stray: got %b%b want 00", inst_data_ok, data_data_ok);
        end
        tick();
        bus_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'h48; bus_addr_ok = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus_req, inst_addr_ok, data_addr_ok} !== 3'b110) begin
            n_fail++;
            $display("FAIL rmid_lock_cleared: got %b want 110", {bus_req, inst_addr_ok, data_addr_ok});
        end
        tick();
        inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            n_fail++;
            $display("FAIL rmid_after: got %b%b want 10", inst_data_ok, data_data_ok);
        end
        tick();
        bus_data_ok = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0; data_wr = 1'b0;
        data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;
        bus_addr_ok = 1'b0; bus_rdata = 32'h0; bus_data_ok = 1'b0;
        test_reset();
        test_single_fetch();
        test_conflict();
        test_lock_hold();
        test_full();
        test_ordering();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
